shift_reg_univ: RTL and testbench

Parametrised universal shift register, the successor to the single-direction serial/parallel shift_reg. It adds selectable direction, a fill mode (serial, rotate, arithmetic, zero), a parallel output, and a frame counter that pulses `done` once every N shifts. It serves as serializer/deserializer, rotator and arithmetic shifter in datapaths and bit-banged links, and is drop-in compatible with shift_reg when dir=0 and mode=00.

---
 rtl/shift_reg_univ.sv | 86 ++++++++
 tb/tb_shift_reg_univ.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Purpose: universal N-bit shift register with selectable direction and fill, and a frame counter.
// Latency: one edge from load/shift to q, dout and done; dout is combinational from q and dir.
// Backpressure: none; en=0 holds q and cnt, and load_en overrides en on the same edge.
//
// Ports:
//   clk      rising-edge clock
//   res_n    asynchronous active-low reset (q=RESET_VAL, cnt=0, done=0)
//   load_en  parallel load strobe; restarts the frame counter
//   load     parallel load data
//   en       shift enable, one position per edge
//   dir      0 = shift toward bit 0, 1 = shift toward bit N-1
//   mode     fill for the vacated bit: 00 din, 01 rotate, 10 arithmetic, 11 zero
//   din      serial input, only used when mode=00
//   dout     serial output: q[0] (dir=0) or q[N-1] (dir=1)
//   q        parallel register contents
//   done     one-cycle pulse on the Nth shift since the last load or reset
module shift_reg_univ #(
  parameter int           N         = 8,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         load_en,
  input  logic [N-1:0] load,
  input  logic         en,
  input  logic         dir,
  input  logic [1:0]   mode,
  input  logic         din,
  output logic         dout,
  output logic [N-1:0] q,
  output logic         done
);

  localparam int            CW      = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt;
  logic          fill;
  logic [N-1:0]  shifted;

  // Fill bit for the position vacated by this shift. din is only looked at
  // in serial mode, so an undriven din cannot leak into q.
  always_comb begin
    fill = 1'b0;
    case (mode)
      2'b00:   fill = din;
      2'b01:   fill = dir ? q[N-1] : q[0];   // the bit being shifted out
      2'b10:   fill = dir ? 1'b0 : q[N-1];   // sign extend only on right shifts
      default: fill = 1'b0;
    endcase
  end

  always_comb begin
    shifted = q;
    if (dir) shifted = {q[N-2:0], fill};
    else     shifted = {fill, q[N-1:1]};
  end

  assign dout = dir ? q[N-1] : q[0];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else if (load_en) begin
      q    <= load;
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      q <= shifted;
      // The Nth shift of a frame wraps the counter and raises done for one cycle.
      if (cnt == CNT_MAX) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_ONE;
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Purpose: directed, table-driven check of shift_reg_univ at N=4, RESET_VAL=0.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; every row is applied for exactly one clock edge.
module tb_shift_reg_univ;

  logic       clk;
  logic       res_n;
  logic       load_en;
  logic [3:0] load;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       din;
  logic       dout;
  logic [3:0] q;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  shift_reg_univ #(.N(4), .RESET_VAL(4'b0000)) dut (
    .clk     (clk),
    .res_n   (res_n),
    .load_en (load_en),
    .load    (load),
    .en      (en),
    .dir     (dir),
    .mode    (mode),
    .din     (din),
    .dout    (dout),
    .q       (q),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       le;
    logic [3:0] ld;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       din;
    logic [3:0] eq;
    logic       edout;
    logic       edone;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic le, input logic [3:0] ld, input logic e,
                             input logic d, input logic [1:0] m, input logic di,
                             input logic [3:0] eq, input logic edout, input logic edone);
    vec_t r;
    r.le = le; r.ld = ld; r.en = e; r.dir = d; r.mode = m; r.din = di;
    r.eq = eq; r.edout = edout; r.edone = edone;
    return r;
  endfunction

  task automatic chk(input string name, input int tag, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %b, want %b", name, tag, act, exp);
    end
  endtask

  task automatic drive(input logic le, input logic [3:0] ld, input logic e,
                       input logic d, input logic [1:0] m, input logic di);
    load_en = le; load = ld; en = e; dir = d; mode = m; din = di;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_n = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);

    //          le  load     en dir mode   din  q        dout done
    // 1: serial in 1,0,1,1 shifting right
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b00, 1, 4'b1000, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b00, 0, 4'b0100, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b00, 1, 4'b1010, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b00, 1, 4'b1101, 1, 1));
    tbl.push_back(v(0, 4'b0000, 0, 0, 2'b00, 0, 4'b1101, 1, 0));
    // 2: rotate right from 1011
    tbl.push_back(v(1, 4'b1011, 0, 0, 2'b01, 0, 4'b1011, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b01, 0, 4'b1101, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b01, 0, 4'b1110, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b01, 0, 4'b0111, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b01, 0, 4'b1011, 1, 1));
    // 3: arithmetic right sign-extends, arithmetic left fills zero
    tbl.push_back(v(1, 4'b1000, 0, 0, 2'b10, 0, 4'b1000, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b10, 0, 4'b1100, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b10, 0, 4'b1110, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b10, 1, 4'b1111, 1, 0));
    tbl.push_back(v(1, 4'b0011, 0, 1, 2'b10, 0, 4'b0011, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b10, 1, 4'b0110, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b10, 1, 4'b1100, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b10, 0, 4'b1000, 1, 0));
    // 4: serial left, zero fill right, direction changes between shifts
    tbl.push_back(v(1, 4'b0000, 0, 1, 2'b00, 0, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b00, 1, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b00, 1, 4'b0011, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b00, 1, 4'b0111, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b00, 1, 4'b1111, 1, 1));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 1, 4'b0111, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 1, 4'b0011, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 1, 2'b11, 1, 4'b0110, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b01, 1, 4'b0011, 1, 1));
    // 5: load wins over en and restarts the frame count
    tbl.push_back(v(1, 4'b1001, 0, 0, 2'b11, 0, 4'b1001, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 0, 4'b0100, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 0, 4'b0010, 0, 0));
    tbl.push_back(v(1, 4'b0110, 1, 0, 2'b11, 0, 4'b0110, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 0, 4'b0011, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 0, 4'b0001, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 0, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2'b11, 0, 4'b0000, 0, 1));

    // Reset state, checked between edges while res_n is low.
    #12;
    chk("reset_q", 0, q, 4'b0000);
    chk("reset_dout", 0, {3'b000, dout}, 4'b0000);
    chk("reset_done", 0, {3'b000, done}, 4'b0000);
    res_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].le, tbl[i].ld, tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].din);
      step();
      chk("row_q", i, q, tbl[i].eq);
      chk("row_dout", i, {3'b000, dout}, {3'b000, tbl[i].edout});
      chk("row_done", i, {3'b000, done}, {3'b000, tbl[i].edone});
    end

    // 12 right rotations of 1011: done on every 4th shift, 3 pulses total.
    begin
      int pulses;
      pulses = 0;
      drive(1'b1, 4'b1011, 1'b0, 1'b0, 2'b01, 1'b0);
      step();
      for (int i = 0; i < 12; i++) begin
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'b01, 1'b0);
        step();
        chk("rot12_done", i, {3'b000, done}, (i % 4 == 3) ? 4'b0001 : 4'b0000);
        if (done) pulses++;
      end
      chk("rot12_q", 12, q, 4'b1011);
      chk("rot12_pulses", 12, pulses[3:0], 4'd3);
    end

    // Reset mid-frame after 3 shifts takes effect before the next edge.
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b1);
      step();
    end
    chk("pre_rst_q", 0, q, 4'b1110);
    #2 res_n = 1'b0;
    #1;
    chk("async_rst_q", 0, q, 4'b0000);
    chk("async_rst_done", 0, {3'b000, done}, 4'b0000);
    @(negedge clk);
    res_n = 1'b1;
    // Fresh frame: only the 4th shift after release pulses done.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_done", i, {3'b000, done}, (i == 3) ? 4'b0001 : 4'b0000);
    end
    chk("post_rst_q", 4, q, 4'b1111);
    // Hold for 5 cycles with a different din: nothing moves.
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_q", i, q, 4'b1111);
      chk("hold_done", i, {3'b000, done}, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
